maze_carve_ctrl: RTL and testbench
==================================

MAZE_CARVE_CTRL -- requirements
Module: maze_carve_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 8, giving the maze bitmap side; it must be a power of two and at least 4.
REQ-002 SHALL have derived constant CELLS = SIZE/2 (cells per side) and CW = max(1, clog2(CELLS)) (cell-coordinate width).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to begin generation, sampled only in IDLE.
REQ-006 SHALL have port rnd, input, 16, random word from the shared LFSR, sampled when used.
REQ-007 SHALL have port wr_valid, output, 1, carve-write request to the maze bitmap.
REQ-008 SHALL have port wr_ready, input, 1, bitmap accepts the write this cycle.
REQ-009 SHALL have ports wr_x and wr_y, output, clog2(SIZE) each, bitmap coordinate to clear.
REQ-010 SHALL have ports push and pop, output, 1 each, stack strobes.
REQ-011 SHALL have port stk_wd, output, 2*CW, push data {x,y}.
REQ-012 SHALL have port stk_rd, input, 2*CW, show-ahead top-of-stack {x,y}.
REQ-013 SHALL have ports stk_empty and stk_full, input, 1 each, stack status.
REQ-014 SHALL have ports busy, done and err, output, 1 each: generation running; maze complete (level); stack overflow (sticky).

Function
REQ-015 SHALL implement states IDLE, PICK, WR_CELL, SELECT, WR_WALL, MOVE, BACK and FIN.
REQ-016 IDLE: on start=1, SHALL clear the internal CELLS x CELLS visited map, clear done and err, set busy, and go to PICK next cycle.
REQ-017 PICK: SHALL load Nx = rnd[CW-1:0] and Ny = rnd[CW+4:5], mark N visited, and go to WR_CELL.
REQ-018 WR_CELL: SHALL drive wr_valid=1 with (wr_x,wr_y) = (2*Nx, 2*Ny); on wr_ready=1 SHALL go to SELECT.
REQ-019 While wr_valid=1 and wr_ready=0, the coordinates SHALL be held stable and the state held.
REQ-020 SELECT: SHALL form the unvisited-neighbour mask over directions 0=N(y-1), 1=E(x+1), 2=S(y+1), 3=W(x-1); out-of-grid neighbours count as unavailable.
REQ-021 SELECT, mask non-zero: SHALL pick the first set direction scanning d0 = rnd[1:0], d0+1, ... modulo 4.
REQ-022 SELECT, mask non-zero: SHALL pulse push with stk_wd = {Nx,Ny}, latch A, and go to WR_WALL.
REQ-023 SELECT, mask zero: SHALL go to BACK.
REQ-024 If stk_full=1 at a required push, SHALL suppress push, set err, and go to FIN.
REQ-025 WR_WALL: SHALL write (Nx+Ax, Ny+Ay), the wall bit between N and A, using the REQ-018/REQ-019 handshake, then go to MOVE.
REQ-026 MOVE: SHALL set N = A and mark A visited in one cycle, then go to WR_CELL.
REQ-027 BACK, stk_empty=1: SHALL go to FIN.
REQ-028 BACK, stk_empty=0: SHALL load N from stk_rd, pulse pop for one cycle, and go to SELECT.
REQ-029 FIN: SHALL set done=1 and busy=0, then go to IDLE; done stays high until the next accepted start.
REQ-030 push and pop SHALL never be asserted in the same cycle.
REQ-031 A start with busy=1 SHALL be ignored.
REQ-032 A full run SHALL issue exactly CELLS^2 cell writes and CELLS^2-1 wall writes.

Reset
REQ-033 On reset, SHALL go to IDLE and clear the visited map and N/A registers.
REQ-034 On reset, every output (wr_valid, wr_x, wr_y, push, pop, stk_wd, busy, done, err) SHALL be 0.
REQ-035 Reset asserted mid-run SHALL abort any pending write without completing it.

Structure
REQ-036 Package maze_pkg SHALL hold the state enum, the direction enum, and dx/dy lookup constants.
REQ-037 Combinational sub-module maze_nbr_pick SHALL compute mask, chosen direction and found flag from visited map, N and d0.

Verification (SIZE=8)
REQ-038 rnd held at 0, wr_ready=1, start pulse -> writes (0,0),(1,0),(2,0),(3,0),(4,0),(5,0),(6,0),(6,1),(6,2) in order.
REQ-039 Any rnd sequence, full run -> 16 cell writes, 15 wall writes, 15 pushes, 15 pops, done=1, err=0, every even-even bitmap cell cleared.
REQ-040 wr_ready held 0 for 5 cycles during WR_WALL -> wr_valid stays 1, coordinates unchanged, no push/pop.
REQ-041 stk_full forced 1 at the first push -> err=1, done=1, no further writes.
REQ-042 start re-pulsed while busy -> no effect; reset mid-WR_CELL -> all outputs 0 next cycle, IDLE.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types and direction lookup tables for the maze carving controller.
package maze_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        WR_CELL,
        SELECT,
        WR_WALL,
        MOVE,
        BACK,
        FIN
    } state_e;

    typedef enum logic [1:0] {
        DIR_N,
        DIR_E,
        DIR_S,
        DIR_W
    } dir_e;

    // Cell-coordinate step per direction, indexed by dir_e (N is y-1).
    localparam int DX [4] = '{0, 1, 0, -1};
    localparam int DY [4] = '{-1, 0, 1, 0};

endpackage

// File: rtl/maze_nbr_pick.sv
// Unvisited-neighbour mask and rotating first-hit direction pick for one cell.
module maze_nbr_pick
    import maze_pkg::*;
#(
    parameter int CELLS = 4,
    parameter int CW    = 2
) (
    input  logic [CELLS*CELLS-1:0] visited,
    input  logic [CW-1:0]          nx,
    input  logic [CW-1:0]          ny,
    input  logic [1:0]             d0,
    output logic [3:0]             mask,
    output dir_e                   dir,
    output logic                   found
);

    logic [3:0] in_grid;

    // CELLS is a power of two, so the grid edge is simply all-zeros / all-ones.
    assign in_grid = {nx != '0, ny != '1, nx != '1, ny != '0};

    for (genvar g = 0; g < 4; g++) begin : g_dir
        logic [CW-1:0] tx;
        logic [CW-1:0] ty;
        assign tx      = nx + CW'(DX[g]);
        assign ty      = ny + CW'(DY[g]);
        assign mask[g] = in_grid[g] && !visited[{ty, tx}];
    end

    always_comb begin
        logic [1:0] d;
        found = 1'b0;
        dir   = DIR_N;
        d     = d0;
        for (int unsigned k = 0; k < 4; k++) begin
            d = d0 + 2'(k);
            if (!found && mask[d]) begin
                found = 1'b1;
                dir   = dir_e'(d);
            end
        end
    end

endmodule

// File: rtl/maze_carve_ctrl.sv
// Recursive-backtracker maze carver: walks a CELLS x CELLS grid, clearing cell and wall bits.
module maze_carve_ctrl
    import maze_pkg::*;
#(
    parameter int SIZE = 8,
    localparam int CELLS = SIZE / 2,
    localparam int CW = (CELLS > 2) ? $clog2(CELLS) : 1,
    localparam int XW = $clog2(SIZE)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [15:0]     rnd,
    output logic            wr_valid,
    input  logic            wr_ready,
    output logic [XW-1:0]   wr_x,
    output logic [XW-1:0]   wr_y,
    output logic            push,
    output logic            pop,
    output logic [2*CW-1:0] stk_wd,
    input  logic [2*CW-1:0] stk_rd,
    input  logic            stk_empty,
    input  logic            stk_full,
    output logic            busy,
    output logic            done,
    output logic            err
);

    state_e                 state, state_nxt;
    logic [CELLS*CELLS-1:0] visited;
    logic [CW-1:0]          nx, ny, ax, ay;
    logic [CW-1:0]          seed_x, seed_y;
    logic [CW-1:0]          pick_x, pick_y;
    logic [3:0]             nbr_mask_unused;
    dir_e                   pick_dir;
    logic                   pick_found;
    logic                   unused_rnd;

    assign unused_rnd = ^rnd;
    assign seed_x     = rnd[CW-1:0];
    assign seed_y     = rnd[CW+4:5];

    maze_nbr_pick #(
        .CELLS (CELLS),
        .CW    (CW)
    ) u_pick (
        .visited (visited),
        .nx      (nx),
        .ny      (ny),
        .d0      (rnd[1:0]),
        .mask    (nbr_mask_unused),
        .dir     (pick_dir),
        .found   (pick_found)
    );

    assign pick_x = nx + CW'(DX[pick_dir]);
    assign pick_y = ny + CW'(DY[pick_dir]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_valid  = 1'b0;
        wr_x      = '0;
        wr_y      = '0;
        push      = 1'b0;
        pop       = 1'b0;
        stk_wd    = '0;
        case (state)
            IDLE:    if (start) state_nxt = PICK;
            PICK:    state_nxt = WR_CELL;
            WR_CELL: begin
                wr_valid = 1'b1;
                wr_x     = {nx, 1'b0};
                wr_y     = {ny, 1'b0};
                if (wr_ready) state_nxt = SELECT;
            end
            SELECT: begin
                if (!pick_found) begin
                    state_nxt = BACK;
                end else if (stk_full) begin
                    state_nxt = FIN;
                end else begin
                    push      = 1'b1;
                    stk_wd    = {nx, ny};
                    state_nxt = WR_WALL;
                end
            end
            WR_WALL: begin
                // Wall bit sits midway between cells 2N and 2A, i.e. at N+A.
                wr_valid = 1'b1;
                wr_x     = {1'b0, nx} + {1'b0, ax};
                wr_y     = {1'b0, ny} + {1'b0, ay};
                if (wr_ready) state_nxt = MOVE;
            end
            MOVE:    state_nxt = WR_CELL;
            BACK: begin
                if (stk_empty) begin
                    state_nxt = FIN;
                end else begin
                    pop       = 1'b1;
                    state_nxt = SELECT;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            visited <= '0;
            nx      <= '0;
            ny      <= '0;
            ax      <= '0;
            ay      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        visited <= '0;
                        done    <= 1'b0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                PICK: begin
                    nx                        <= seed_x;
                    ny                        <= seed_y;
                    visited[{seed_y, seed_x}] <= 1'b1;
                end
                SELECT: begin
                    if (pick_found && !stk_full) begin
                        ax <= pick_x;
                        ay <= pick_y;
                    end
                    if (pick_found && stk_full) err <= 1'b1;
                end
                MOVE: begin
                    nx              <= ax;
                    ny              <= ay;
                    visited[{ay, ax}] <= 1'b1;
                end
                BACK: begin
                    if (!stk_empty) begin
                        nx <= stk_rd[2*CW-1:CW];
                        ny <= stk_rd[CW-1:0];
                    end
                end
                FIN: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_carve_ctrl.sv
// Self-checking bench: stack/bitmap environment plus a cell-level backtracker reference.
module tb_maze_carve_ctrl;

    localparam int SIZE  = 8;
    localparam int CELLS = SIZE / 2;
    localparam int CW    = 2;
    localparam int XW    = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [15:0]     rnd;
    logic            wr_valid;
    logic            wr_ready;
    logic [XW-1:0]   wr_x, wr_y;
    logic            push, pop;
    logic [2*CW-1:0] stk_wd, stk_rd;
    logic            stk_empty, stk_full;
    logic            busy, done, err;

    maze_carve_ctrl #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rnd       (rnd),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .push      (push),
        .pop       (pop),
        .stk_wd    (stk_wd),
        .stk_rd    (stk_rd),
        .stk_empty (stk_empty),
        .stk_full  (stk_full),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rdy;
        logic [2:0] ex;
        logic [2:0] ey;
    } vec_t;

    int          n_chk, n_pass;
    logic [15:0] seq [64];
    int          k_idx;
    logic [5:0]  exp_w [$];
    logic [3:0]  exp_pd [$];
    int          exp_push_n, exp_pop_n, exp_cells;
    logic        exp_err;
    int          wi, pi, cell_cnt, wall_cnt, push_cnt, pop_cnt;
    logic [3:0]  stkq [$];
    logic        bitmap [SIZE][SIZE];
    logic        s_valid, s_busy, s_done, s_err;
    logic [2:0]  s_x, s_y;
    logic        rand_ready, rand_start, ready_val, full_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    endtask

    task automatic drive_stack();
        stk_rd    = (stkq.size() > 0) ? stkq[$] : 4'h0;
        stk_empty = (stkq.size() == 0);
        stk_full  = full_val;
    endtask

    // Reference: depth-first carve on a cell grid, one rnd word per decision.
    task automatic build_model();
        int vis [CELLS][CELLS];
        int sx [$];
        int sy [$];
        int x, y, k, chosen, tx, ty, d;
        int ddx [4] = '{0, 1, 0, -1};
        int ddy [4] = '{-1, 0, 1, 0};
        exp_w.delete();
        exp_pd.delete();
        exp_push_n = 0;
        exp_pop_n  = 0;
        exp_err    = 1'b0;
        foreach (vis[i, j]) vis[i][j] = 0;
        x = int'(seq[0]) % CELLS;
        y = (int'(seq[0]) >> 5) % CELLS;
        vis[x][y] = 1;
        exp_w.push_back({3'(2 * x), 3'(2 * y)});
        exp_cells = 1;
        k = 0;
        while (k < 63) begin
            k++;
            chosen = -1;
            for (int j = 0; j < 4; j++) begin
                d  = (int'(seq[k] & 16'h3) + j) % 4;
                tx = x + ddx[d];
                ty = y + ddy[d];
                if (chosen < 0 && tx >= 0 && tx < CELLS && ty >= 0 && ty < CELLS)
                    if (vis[tx][ty] == 0) chosen = d;
            end
            if (chosen >= 0) begin
                if (full_val) begin
                    exp_err = 1'b1;
                    break;
                end
                exp_pd.push_back({2'(x), 2'(y)});
                exp_push_n++;
                sx.push_back(x);
                sy.push_back(y);
                tx = x + ddx[chosen];
                ty = y + ddy[chosen];
                exp_w.push_back({3'(x + tx), 3'(y + ty)});
                x = tx;
                y = ty;
                vis[x][y] = 1;
                exp_w.push_back({3'(2 * x), 3'(2 * y)});
                exp_cells++;
            end else if (sx.size() == 0) begin
                break;
            end else begin
                x = sx.pop_back();
                y = sy.pop_back();
                exp_pop_n++;
            end
        end
    endtask

    task automatic cycle();
        logic       ev, pend_push, pend_pop;
        logic [3:0] pd;
        ev = 1'b0; pend_push = 1'b0; pend_pop = 1'b0; pd = '0;
        @(negedge clk);
        s_valid = wr_valid; s_x = wr_x; s_y = wr_y;
        s_busy = busy; s_done = done; s_err = err;
        if (push || pop) chk("push_pop_excl", 32'(push & pop), 32'(0));
        if (wr_valid && wr_ready) begin
            if (wi < exp_w.size()) begin
                chk("wr_x", 32'(wr_x), 32'(exp_w[wi][5:3]));
                chk("wr_y", 32'(wr_y), 32'(exp_w[wi][2:0]));
            end else chk("extra_write", 32'(wi), 32'(exp_w.size()));
            wi++;
            if (!wr_x[0] && !wr_y[0]) begin cell_cnt++; ev = 1'b1; end
            else wall_cnt++;
            bitmap[wr_x][wr_y] = 1'b0;
        end
        if (push) begin
            if (pi < exp_pd.size()) chk("push_data", 32'(stk_wd), 32'(exp_pd[pi]));
            else chk("extra_push", 32'(pi), 32'(exp_pd.size()));
            pi++; push_cnt++; pend_push = 1'b1; pd = stk_wd;
        end
        if (pop) begin pop_cnt++; pend_pop = 1'b1; ev = 1'b1; end
        @(posedge clk);
        #1;
        if (pend_push) stkq.push_back(pd);
        if (pend_pop && stkq.size() > 0) void'(stkq.pop_back());
        drive_stack();
        if (ev && k_idx < 63) k_idx++;
        rnd      = seq[k_idx];
        wr_ready = rand_ready ? ($urandom_range(0, 9) < 7) : ready_val;
        start    = rand_start && s_valid && ($urandom_range(0, 5) == 0);
    endtask

    task automatic start_run(input bit random_seq);
        foreach (seq[i]) seq[i] = random_seq ? 16'($urandom) : 16'h0;
        build_model();
        wi = 0; pi = 0; cell_cnt = 0; wall_cnt = 0; push_cnt = 0; pop_cnt = 0; k_idx = 0;
        foreach (bitmap[i, j]) bitmap[i][j] = 1'b1;
        stkq.delete();
        drive_stack();
        rnd   = seq[0];
        start = 1'b1;
        cycle();
        cycle();
        chk("busy_running", 32'(s_busy), 32'(1));
        chk("done_cleared", 32'(s_done), 32'(0));
        chk("err_cleared", 32'(s_err), 32'(0));
    endtask

    task automatic finish_run();
        bit seen;
        int ev_cl, oo_cl;
        seen = 1'b0; ev_cl = 0; oo_cl = 0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            cycle();
            if (s_done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'(1));
        chk("err_flag", 32'(s_err), 32'(exp_err));
        chk("busy_end", 32'(s_busy), 32'(0));
        chk("write_total", 32'(wi), 32'(exp_w.size()));
        chk("cell_writes", 32'(cell_cnt), 32'(exp_cells));
        chk("wall_writes", 32'(wall_cnt), 32'(exp_w.size() - exp_cells));
        chk("push_count", 32'(push_cnt), 32'(exp_push_n));
        chk("pop_count", 32'(pop_cnt), 32'(exp_pop_n));
        chk("stack_drained", 32'(stkq.size()), 32'(0));
        if (!exp_err) begin
            chk("cells_all", 32'(cell_cnt), 32'(CELLS * CELLS));
            chk("walls_all", 32'(wall_cnt), 32'(CELLS * CELLS - 1));
        end
        foreach (bitmap[i, j]) begin
            if (i % 2 == 0 && j % 2 == 0 && !bitmap[i][j]) ev_cl++;
            if (i % 2 == 1 && j % 2 == 1 && !bitmap[i][j]) oo_cl++;
        end
        chk("even_cells_cleared", 32'(ev_cl), 32'(exp_cells));
        chk("odd_odd_untouched", 32'(oo_cl), 32'(0));
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_wr_valid"}, 32'(wr_valid), 32'(0));
        chk({tag, "_wr_xy"}, 32'({wr_x, wr_y}), 32'(0));
        chk({tag, "_push_pop"}, 32'({push, pop}), 32'(0));
        chk({tag, "_stk_wd"}, 32'(stk_wd), 32'(0));
        chk({tag, "_flags"}, 32'({busy, done, err}), 32'(0));
    endtask

    initial begin
        vec_t tbl [14];
        bit   seen;
        n_chk = 0; n_pass = 0;
        rand_ready = 1'b0; rand_start = 1'b0; ready_val = 1'b1; full_val = 1'b0;
        foreach (seq[i]) seq[i] = '0;
        k_idx = 0; wi = 0; pi = 0;
        reset = 1'b1; start = 1'b0; rnd = '0; wr_ready = 1'b0;
        drive_stack();

        // rnd held at 0: straight east along row 0, then south; 5-cycle stall on the first wall.
        tbl[0]  = '{1'b1, 3'd0, 3'd0};
        for (int i = 1; i <= 5; i++) tbl[i] = '{1'b0, 3'd1, 3'd0};
        tbl[6]  = '{1'b1, 3'd1, 3'd0};
        tbl[7]  = '{1'b1, 3'd2, 3'd0};
        tbl[8]  = '{1'b1, 3'd3, 3'd0};
        tbl[9]  = '{1'b1, 3'd4, 3'd0};
        tbl[10] = '{1'b1, 3'd5, 3'd0};
        tbl[11] = '{1'b1, 3'd6, 3'd0};
        tbl[12] = '{1'b1, 3'd6, 3'd1};
        tbl[13] = '{1'b1, 3'd6, 3'd2};

        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        reset = 1'b0;

        start_run(1'b0);
        foreach (tbl[i]) begin
            ready_val = tbl[i].rdy;
            wr_ready  = tbl[i].rdy;
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                cycle();
                if (s_valid) seen = 1'b1;
            end
            chk("tbl_valid", 32'(seen), 32'(1));
            chk("tbl_x", 32'(s_x), 32'(tbl[i].ex));
            chk("tbl_y", 32'(s_y), 32'(tbl[i].ey));
            if (i == 5) begin
                chk("stall_push_cnt", 32'(push_cnt), 32'(1));
                chk("stall_pop_cnt", 32'(pop_cnt), 32'(0));
            end
        end
        ready_val = 1'b1;
        finish_run();

        rand_ready = 1'b1;
        rand_start = 1'b1;
        for (int r = 0; r < 6; r++) begin
            start_run(1'b1);
            finish_run();
        end

        full_val = 1'b1;
        start_run(1'b1);
        finish_run();
        repeat (10) cycle();
        chk("full_no_more_writes", 32'(wi), 32'(1));
        full_val = 1'b0;
        start_run(1'b1);
        finish_run();

        rand_ready = 1'b0;
        rand_start = 1'b0;
        ready_val  = 1'b0;
        start_run(1'b1);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            cycle();
            if (s_valid) seen = 1'b1;
        end
        chk("rst_reach_wr_cell", 32'(seen), 32'(1));
        reset = 1'b1;
        #1;
        chk_outputs_zero("rst_async");
        stkq.delete();
        drive_stack();
        @(posedge clk);
        #1;
        chk_outputs_zero("rst_held");
        reset     = 1'b0;
        ready_val = 1'b1;
        wr_ready  = 1'b1;
        repeat (6) cycle();
        chk("rst_no_write", 32'(wi), 32'(0));
        chk("rst_idle_busy", 32'(s_busy), 32'(0));
        chk("rst_idle_valid", 32'(s_valid), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
